// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//
// Feeds the 16-bit ALU of the von Neumann datapath. One request (function
// code plus A/B source addresses and Z destination address) is accepted at a
// time. Both operands are fetched serially over the shared memory bus. The
// ALU result is captured in the single EXEC cycle and then written back to Z.
// DONE pulses once the write completes.
//
// Optional feature (compile-time macro ALU_SEQ_TIMEOUT_EN):
//   Defined   - every bus transfer is limited to TIMEOUT_CYC cycles. On expiry
//               the strobe drops, ERR pulses for one cycle and the sequencer
//               returns to IDLE without DONE. An ACK in the expiry cycle wins.
//   Undefined - transfers wait for MEM_ACK indefinitely; ERR is always 0.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   REQ_VALID / REQ_READY     request handshake (READY only in IDLE)
//   REQ_FUN, REQ_ADDR_A/B/Z   function code and addresses, latched on accept
//   MEM_ADDR, MEM_RD, MEM_WR  shared bus address and strobes (held until ACK)
//   MEM_WDATA, MEM_RDATA      bus write / read data
//   MEM_ACK                   bus transfer complete
//   ALU_A, ALU_B, ALU_FUN     registered ALU operands and function code
//   ALU_Z                     combinational ALU result
//   RESULT                    last captured ALU_Z
//   DONE                      one-cycle pulse after writeback
//   ERR                       one-cycle pulse on bus timeout
//
// state  | meaning
// IDLE   | ready for a request; DONE/ERR of the previous op visible here
// RD_A   | reading operand A from addr_a, waiting for MEM_ACK
// RD_B   | reading operand B from addr_b, waiting for MEM_ACK
// EXEC   | single cycle: capture ALU_Z into RESULT
// WR_Z   | writing RESULT to addr_z, waiting for MEM_ACK

module alu_operand_sequencer #(
    parameter int unsigned DW          = 16,
    parameter int unsigned AW          = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [1:0]    REQ_FUN,
    input  logic [AW-1:0] REQ_ADDR_A,
    input  logic [AW-1:0] REQ_ADDR_B,
    input  logic [AW-1:0] REQ_ADDR_Z,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_RD,
    output logic          MEM_WR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic          MEM_ACK,
    output logic [DW-1:0] ALU_A,
    output logic [DW-1:0] ALU_B,
    output logic [1:0]    ALU_FUN,
    input  logic [DW-1:0] ALU_Z,
    output logic [DW-1:0] RESULT,
    output logic          DONE,
    output logic          ERR
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WR_Z = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    fun_q, fun_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [AW-1:0] addr_b_q, addr_b_d;
    logic [AW-1:0] addr_z_q, addr_z_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [DW-1:0] result_q, result_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          timeout_hit;
    logic          in_bus;

    assign in_bus = (state_q == ST_RD_A) || (state_q == ST_RD_B) || (state_q == ST_WR_Z);

`ifdef ALU_SEQ_TIMEOUT_EN
    // Down-counter reloaded outside a waiting transfer; reaching zero with no
    // ACK in that cycle means TIMEOUT_CYC strobe cycles have gone unanswered.
    localparam int unsigned   CW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] wait_q, wait_d;

    always_comb begin
        wait_d = WAIT_LOAD;
        if (in_bus && !MEM_ACK) begin
            wait_d = wait_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign timeout_hit = in_bus && !MEM_ACK && (wait_q == '0);
`else
    localparam int unsigned timeout_cyc_unused = TIMEOUT_CYC;

    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        fun_d    = fun_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_z_d = addr_z_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    fun_d    = REQ_FUN;
                    addr_a_d = REQ_ADDR_A;
                    addr_b_d = REQ_ADDR_B;
                    addr_z_d = REQ_ADDR_Z;
                    state_d  = ST_RD_A;
                end
            end
            ST_RD_A: begin
                if (MEM_ACK) begin
                    alu_a_d = MEM_RDATA;
                    state_d = ST_RD_B;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_B: begin
                if (MEM_ACK) begin
                    alu_b_d = MEM_RDATA;
                    state_d = ST_EXEC;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                result_d = ALU_Z;
                state_d  = ST_WR_Z;
            end
            ST_WR_Z: begin
                if (MEM_ACK) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            fun_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_z_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fun_q    <= fun_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_z_q <= addr_z_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Bus outputs decode from the registered state only, so address and
    // strobe cannot glitch while a transfer waits for ACK.
    always_comb begin
        MEM_ADDR  = '0;
        MEM_RD    = 1'b0;
        MEM_WR    = 1'b0;
        MEM_WDATA = '0;
        case (state_q)
            ST_RD_A: begin
                MEM_RD   = 1'b1;
                MEM_ADDR = addr_a_q;
            end
            ST_RD_B: begin
                MEM_RD   = 1'b1;
                MEM_ADDR = addr_b_q;
            end
            ST_WR_Z: begin
                MEM_WR    = 1'b1;
                MEM_ADDR  = addr_z_q;
                MEM_WDATA = result_q;
            end
            default: begin
            end
        endcase
    end

    assign REQ_READY = (state_q == ST_IDLE);
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_FUN   = fun_q;
    assign RESULT    = result_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic        CLK;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [1:0]  REQ_FUN;
    logic [7:0]  REQ_ADDR_A;
    logic [7:0]  REQ_ADDR_B;
    logic [7:0]  REQ_ADDR_Z;
    logic [7:0]  MEM_ADDR;
    logic        MEM_RD;
    logic        MEM_WR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;
    logic        MEM_ACK;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic [1:0]  ALU_FUN;
    logic [15:0] ALU_Z;
    logic [15:0] RESULT;
    logic        DONE;
    logic        ERR;

    alu_operand_sequencer #(
        .DW(16),
        .AW(8),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_FUN(REQ_FUN),
        .REQ_ADDR_A(REQ_ADDR_A),
        .REQ_ADDR_B(REQ_ADDR_B),
        .REQ_ADDR_Z(REQ_ADDR_Z),
        .MEM_ADDR(MEM_ADDR),
        .MEM_RD(MEM_RD),
        .MEM_WR(MEM_WR),
        .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA),
        .MEM_ACK(MEM_ACK),
        .ALU_A(ALU_A),
        .ALU_B(ALU_B),
        .ALU_FUN(ALU_FUN),
        .ALU_Z(ALU_Z),
        .RESULT(RESULT),
        .DONE(DONE),
        .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ALU stub
    assign ALU_Z = ALU_A + ALU_B;

    // Memory responder: ACK after ack_delay wait cycles; writes can be withheld.
    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    txn_t        txq [$];
    int          wcnt = 0;
    int          ack_delay = 0;
    bit          withhold_wr = 1'b0;
    bit          preload_req = 1'b0;

    assign MEM_RDATA = mem[MEM_ADDR];
    assign MEM_ACK   = (MEM_RD || MEM_WR) && !(MEM_WR && withhold_wr) && (wcnt == ack_delay);

    always @(posedge CLK) begin
        if (preload_req) begin
            for (int i = 0; i < 256; i++) mem[i] = ref_mem[i];
        end
        if (MEM_WR && MEM_ACK) mem[MEM_ADDR] = MEM_WDATA;
        if ((MEM_RD || MEM_WR) && !MEM_ACK) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (!RST && MEM_ACK) txq.push_back({MEM_WR, MEM_ADDR, MEM_WR ? MEM_WDATA : MEM_RDATA});
    end

    int n_pass = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advances cycle by cycle until DONE or ERR (or budget), checking bus rules.
    task automatic wait_done(input int budget, output int lat, output bit bus_ok);
        bit         pend;
        logic [7:0] paddr;
        logic       pwr;
        lat = 0; bus_ok = 1'b1; pend = 1'b0; paddr = '0; pwr = 1'b0;
        do begin
            @(posedge CLK); @(negedge CLK);
            lat++;
            if (MEM_RD && MEM_WR) bus_ok = 1'b0;
            if (!MEM_RD && !MEM_WR && MEM_ADDR != 8'h00) bus_ok = 1'b0;
            if (pend && (!(MEM_RD || MEM_WR) || MEM_WR != pwr || MEM_ADDR != paddr)) bus_ok = 1'b0;
            pend  = (MEM_RD || MEM_WR) && !MEM_ACK;
            paddr = MEM_ADDR;
            pwr   = MEM_WR;
        end while (!DONE && !ERR && lat < budget);
    endtask

    task automatic check_txns(input string tag, input logic [7:0] a, input logic [15:0] ea,
                              input logic [7:0] b, input logic [15:0] eb,
                              input logic [7:0] z, input logic [15:0] er);
        txn_t exp_t [3];
        exp_t[0] = {1'b0, a, ea};
        exp_t[1] = {1'b0, b, eb};
        exp_t[2] = {1'b1, z, er};
        chk({tag, "_ntxn"}, 32'(txq.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (txq.size() > 0) chk({tag, "_txn"}, 32'(txq.pop_front()), 32'(exp_t[i]));
        end
        txq.delete();
    endtask

    task automatic do_op(input string tag, input logic [1:0] fun, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] z, input int dly);
        logic [15:0] ea, eb, er;
        int lat;
        bit ok;
        ea = ref_mem[a];
        eb = ref_mem[b];
        er = ea + eb;
        ack_delay = dly;
        chk({tag, "_ready"}, 32'(REQ_READY), 32'd1);
        REQ_FUN = fun; REQ_ADDR_A = a; REQ_ADDR_B = b; REQ_ADDR_Z = z; REQ_VALID = 1'b1;
        @(posedge CLK); @(negedge CLK);
        REQ_VALID = 1'b0;
        chk({tag, "_busy"}, 32'(REQ_READY), 32'd0);
        wait_done(5 + 3 * dly + 20, lat, ok);
        chk({tag, "_lat"}, 32'(lat + 1), 32'(5 + 3 * dly));
        chk({tag, "_done"}, 32'(DONE), 32'd1);
        chk({tag, "_ready_done"}, 32'(REQ_READY), 32'd1);
        chk({tag, "_alu_a"}, 32'(ALU_A), 32'(ea));
        chk({tag, "_alu_b"}, 32'(ALU_B), 32'(eb));
        chk({tag, "_alu_fun"}, 32'(ALU_FUN), 32'(fun));
        chk({tag, "_result"}, 32'(RESULT), 32'(er));
        chk({tag, "_bus"}, 32'(ok), 32'd1);
        check_txns(tag, a, ea, b, eb, z, er);
        ref_mem[z] = er;
        chk({tag, "_mem_z"}, 32'(mem[z]), 32'(er));
        @(posedge CLK); @(negedge CLK);
        chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [15:0] a1, b1, r1, a2, b2, r2, old_z;
    int          lat, extra;
    bit          ok, found, saw_done;

    initial begin
        RST = 1'b1; REQ_VALID = 1'b0; REQ_FUN = '0;
        REQ_ADDR_A = '0; REQ_ADDR_B = '0; REQ_ADDR_Z = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
        ref_mem[8'h10] = 16'h000B;
        ref_mem[8'h11] = 16'h0269;
        @(negedge CLK); preload_req = 1'b1;
        @(negedge CLK); preload_req = 1'b0;
        @(negedge CLK);

        // reset state
        chk("rst_ready", 32'(REQ_READY), 32'd1);
        chk("rst_bus", 32'({MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA}), 32'd0);
        chk("rst_alu", 32'({ALU_A, ALU_B}), 32'd0);
        chk("rst_fun_res", 32'({ALU_FUN, RESULT}), 32'd0);
        chk("rst_flags", 32'({DONE, ERR}), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // zero-wait op with spec values
        do_op("t1", 2'b01, 8'h10, 8'h11, 8'h12, 0);
        chk("t1_result_lit", 32'(RESULT), 32'h0274);
        chk("t1_mem_lit", 32'(mem[8'h12]), 32'h0274);
        chk("t1_alu_lit", 32'({ALU_A, ALU_B}), 32'h000B_0269);

        // full aliasing: A=B=Z
        do_op("t3", 2'b10, 8'h10, 8'h10, 8'h10, 0);
        chk("t3_result_lit", 32'(RESULT), 32'h0016);
        chk("t3_mem_lit", 32'(mem[8'h10]), 32'h0016);

        // three wait cycles on every transfer
        do_op("t2", 2'b11, 8'h05, 8'h06, 8'h07, 3);

        // REQ_VALID held: second request accepted in the DONE cycle
        a1 = ref_mem[8'h20]; b1 = ref_mem[8'h21]; r1 = a1 + b1;
        ref_mem[8'h22] = r1;
        a2 = ref_mem[8'h22]; b2 = ref_mem[8'h20]; r2 = a2 + b2;
        ref_mem[8'h23] = r2;
        ack_delay = 0;
        REQ_FUN = 2'b01; REQ_ADDR_A = 8'h20; REQ_ADDR_B = 8'h21; REQ_ADDR_Z = 8'h22;
        REQ_VALID = 1'b1;
        @(posedge CLK); @(negedge CLK);
        REQ_FUN = 2'b10; REQ_ADDR_A = 8'h22; REQ_ADDR_B = 8'h20; REQ_ADDR_Z = 8'h23;
        chk("t4_busy", 32'(REQ_READY), 32'd0);
        wait_done(40, lat, ok);
        chk("t4_lat1", 32'(lat + 1), 32'd5);
        chk("t4_done1", 32'(DONE), 32'd1);
        chk("t4_ready_done", 32'(REQ_READY), 32'd1);
        chk("t4_res1", 32'(RESULT), 32'(r1));
        check_txns("t4_op1", 8'h20, a1, 8'h21, b1, 8'h22, r1);
        @(posedge CLK); @(negedge CLK);
        REQ_VALID = 1'b0;
        chk("t4_accept2", 32'({DONE, REQ_READY}), 32'd0);
        wait_done(40, lat, ok);
        chk("t4_lat2", 32'(lat + 1), 32'd5);
        chk("t4_done2", 32'(DONE), 32'd1);
        chk("t4_res2", 32'(RESULT), 32'(r2));
        chk("t4_fun2", 32'(ALU_FUN), 32'd2);
        check_txns("t4_op2", 8'h22, a2, 8'h20, b2, 8'h23, r2);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); @(negedge CLK);
            if (DONE || !REQ_READY) extra++;
        end
        chk("t4_no_dup", 32'(extra), 32'd0);
        chk("t4_no_txn", 32'(txq.size()), 32'd0);
        chk("t4_mem23", 32'(mem[8'h23]), 32'(r2));

        // reset during RD_B with ACK pending
        ack_delay = 6;
        old_z = ref_mem[8'h32];
        REQ_FUN = 2'b11; REQ_ADDR_A = 8'h30; REQ_ADDR_B = 8'h31; REQ_ADDR_Z = 8'h32;
        REQ_VALID = 1'b1;
        @(posedge CLK); @(negedge CLK);
        REQ_VALID = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge CLK); @(negedge CLK);
            if (MEM_RD && MEM_ADDR == 8'h31) found = 1'b1;
        end
        chk("t5_in_rd_b", 32'(found), 32'd1);
        RST = 1'b1;
        @(posedge CLK); @(negedge CLK);
        chk("t5_ready", 32'(REQ_READY), 32'd1);
        chk("t5_bus", 32'({MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA}), 32'd0);
        chk("t5_alu", 32'({ALU_A, ALU_B}), 32'd0);
        chk("t5_fun_res", 32'({ALU_FUN, RESULT}), 32'd0);
        chk("t5_flags", 32'({DONE, ERR}), 32'd0);
        RST = 1'b0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); @(negedge CLK);
            if (DONE || ERR || MEM_RD || MEM_WR) extra++;
        end
        chk("t5_quiet", 32'(extra), 32'd0);
        chk("t5_mem_z", 32'(mem[8'h32]), 32'(old_z));
        txq.delete();

        // ACK in the last permitted wait cycle still completes normally
        do_op("late_ack", 2'b00, 8'h08, 8'h09, 8'h0A, TO - 1);

        // randomized ops over a small window to provoke aliasing
        for (int n = 0; n < 12; n++) begin
            do_op("rnd", 2'($urandom), 8'(8'h40 + $urandom_range(0, 7)),
                  8'(8'h40 + $urandom_range(0, 7)), 8'(8'h40 + $urandom_range(0, 7)),
                  int'($urandom_range(0, 3)));
        end

`ifdef ALU_SEQ_TIMEOUT_EN
        // ACK withheld in WR_Z
        a1 = ref_mem[8'h50]; b1 = ref_mem[8'h51]; r1 = a1 + b1;
        old_z = ref_mem[8'h52];
        ack_delay = 0;
        withhold_wr = 1'b1;
        REQ_FUN = 2'b01; REQ_ADDR_A = 8'h50; REQ_ADDR_B = 8'h51; REQ_ADDR_Z = 8'h52;
        REQ_VALID = 1'b1;
        @(posedge CLK); @(negedge CLK);
        REQ_VALID = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge CLK); @(negedge CLK);
            if (MEM_WR) found = 1'b1;
        end
        chk("t6_in_wr_z", 32'(found), 32'd1);
        lat = 0; saw_done = 1'b0;
        while (!ERR && lat < 30) begin
            @(posedge CLK); @(negedge CLK);
            lat++;
            if (DONE) saw_done = 1'b1;
        end
        chk("t6_err_lat", 32'(lat), 32'(TO));
        chk("t6_err", 32'(ERR), 32'd1);
        chk("t6_no_done", 32'(saw_done), 32'd0);
        chk("t6_idle", 32'({REQ_READY, MEM_WR}), 32'b10);
        chk("t6_result", 32'(RESULT), 32'(r1));
        chk("t6_mem_z", 32'(mem[8'h52]), 32'(old_z));
        chk("t6_ntxn", 32'(txq.size()), 32'd2);
        @(posedge CLK); @(negedge CLK);
        chk("t6_err_pulse", 32'(ERR), 32'd0);
        txq.delete();
        withhold_wr = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
